// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge: registered APB4 slave-to-master bridge, one transfer in flight; APB_BRIDGE_TIMEOUT_EN enables the downstream wait timeout.
// Latency: m_apb_psel 1 cycle after upstream setup, s_apb_pready 3 cycles after setup plus one per downstream wait cycle.
// Backpressure: upstream is held in its access phase until RESP; downstream waits stall the bridge (or abort after G_TIMEOUT with the macro).
module apb_reg_bridge #(
    parameter int G_REGWIDTH   = 32,
    parameter int G_ADDR_WIDTH = 32,
    parameter int G_TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_apb_psel,
    input  logic                      s_apb_penable,
    input  logic                      s_apb_pwrite,
    input  logic [2:0]                s_apb_pprot,
    input  logic [G_ADDR_WIDTH-1:0]   s_apb_paddr,
    input  logic [G_REGWIDTH-1:0]     s_apb_pwdata,
    input  logic [G_REGWIDTH/8-1:0]   s_apb_pstrb,
    output logic                      s_apb_pready,
    output logic [G_REGWIDTH-1:0]     s_apb_prdata,
    output logic                      s_apb_pslverr,
    output logic                      m_apb_psel,
    output logic                      m_apb_penable,
    output logic                      m_apb_pwrite,
    output logic [2:0]                m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0]   m_apb_paddr,
    output logic [G_REGWIDTH-1:0]     m_apb_pwdata,
    output logic [G_REGWIDTH/8-1:0]   m_apb_pstrb,
    input  logic                      m_apb_pready,
    input  logic [G_REGWIDTH-1:0]     m_apb_prdata,
    input  logic                      m_apb_pslverr,
    output logic                      timeout_evt
);
    if (G_REGWIDTH != 8 && G_REGWIDTH != 16 && G_REGWIDTH != 32) begin : g_bad_width
        $error("apb_reg_bridge: G_REGWIDTH must be 8, 16 or 32");
    end
    if (G_TIMEOUT < 1 || G_TIMEOUT > 65535) begin : g_bad_timeout
        $error("apb_reg_bridge: G_TIMEOUT must be 1..65535");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t r_state;
    state_t w_next;
    logic   r_drop;
    logic   w_drop;
    logic   w_done;
    logic   w_tmo;

    logic                      r_m_psel;
    logic                      r_m_penable;
    logic                      r_pwrite;
    logic [2:0]                r_pprot;
    logic [G_ADDR_WIDTH-1:0]   r_paddr;
    logic [G_REGWIDTH-1:0]     r_pwdata;
    logic [G_REGWIDTH/8-1:0]   r_pstrb;
    logic                      r_s_pready;
    logic [G_REGWIDTH-1:0]     r_s_prdata;
    logic                      r_s_pslverr;

    assign w_done = (r_state == S_ACCESS) && m_apb_pready;
    // Upstream master abandoning the transfer: finish downstream, then skip RESP.
    assign w_drop = r_drop || !s_apb_psel;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int                 C_CNT_W = $clog2(G_TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_TMO   = C_CNT_W'(G_TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_tevt;

    // A ready arriving on the limit cycle wins over the timeout.
    assign w_tmo       = (r_state == S_ACCESS) && !m_apb_pready && (r_cnt == C_TMO);
    assign timeout_evt = r_tevt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tevt <= 1'b0;
        end else begin
            r_tevt <= w_tmo;
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if (r_state == S_ACCESS && !m_apb_pready) begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end
`else
    assign w_tmo       = 1'b0;
    assign timeout_evt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (s_apb_psel && !s_apb_penable) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done || w_tmo) w_next = w_drop ? S_IDLE : S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwrite <= 1'b0;
            r_pprot  <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_drop <= 1'b0;
                if (s_apb_psel && !s_apb_penable) begin
                    r_pwrite <= s_apb_pwrite;
                    r_pprot  <= s_apb_pprot;
                    r_paddr  <= s_apb_paddr;
                    r_pwdata <= s_apb_pwdata;
                    r_pstrb  <= s_apb_pwrite ? s_apb_pstrb : '0;
                end
            end else begin
                r_drop <= w_drop;
            end
        end
    end

    // Outputs are registered from the next state so every port comes straight off a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_psel    <= 1'b0;
            r_m_penable <= 1'b0;
            r_s_pready  <= 1'b0;
            r_s_prdata  <= '0;
            r_s_pslverr <= 1'b0;
        end else begin
            r_m_psel    <= (w_next == S_SETUP) || (w_next == S_ACCESS);
            r_m_penable <= (w_next == S_ACCESS);
            r_s_pready  <= (w_next == S_RESP);
            r_s_pslverr <= (w_next == S_RESP) && (w_tmo || m_apb_pslverr);
            if (w_next == S_RESP && w_done && !r_pwrite) begin
                r_s_prdata <= m_apb_prdata;
            end else begin
                r_s_prdata <= '0;
            end
        end
    end

    assign m_apb_psel    = r_m_psel;
    assign m_apb_penable = r_m_penable;
    assign m_apb_pwrite  = r_pwrite;
    assign m_apb_pprot   = r_pprot;
    assign m_apb_paddr   = r_paddr;
    assign m_apb_pwdata  = r_pwdata;
    assign m_apb_pstrb   = r_pstrb;
    assign s_apb_pready  = r_s_pready;
    assign s_apb_prdata  = r_s_prdata;
    assign s_apb_pslverr = r_s_pslverr;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Scoreboard bench for apb_reg_bridge: directed transfers push expected responses, monitors compare.
module tb_apb_reg_bridge;
    localparam int G_TMO = 4;
`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int C_EXP_TEVT = 1;
`else
    localparam int C_EXP_TEVT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s_psel, s_penable, s_pwrite;
    logic [2:0]  s_pprot;
    logic [31:0] s_paddr, s_pwdata;
    logic [3:0]  s_pstrb;
    logic        s_pready, s_pslverr;
    logic [31:0] s_prdata;
    logic        m_psel, m_penable, m_pwrite;
    logic [2:0]  m_pprot;
    logic [31:0] m_paddr, m_pwdata;
    logic [3:0]  m_pstrb;
    logic        m_pready, m_pslverr;
    logic [31:0] m_prdata;
    logic        tevt;

    apb_reg_bridge #(.G_REGWIDTH(32), .G_ADDR_WIDTH(32), .G_TIMEOUT(G_TMO)) dut (
        .clk(clk), .rst(rst),
        .s_apb_psel(s_psel), .s_apb_penable(s_penable), .s_apb_pwrite(s_pwrite),
        .s_apb_pprot(s_pprot), .s_apb_paddr(s_paddr), .s_apb_pwdata(s_pwdata),
        .s_apb_pstrb(s_pstrb), .s_apb_pready(s_pready), .s_apb_prdata(s_prdata),
        .s_apb_pslverr(s_pslverr),
        .m_apb_psel(m_psel), .m_apb_penable(m_penable), .m_apb_pwrite(m_pwrite),
        .m_apb_pprot(m_pprot), .m_apb_paddr(m_paddr), .m_apb_pwdata(m_pwdata),
        .m_apb_pstrb(m_pstrb), .m_apb_pready(m_pready), .m_apb_prdata(m_prdata),
        .m_apb_pslverr(m_pslverr), .timeout_evt(tevt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        tevt;
        int          cyc;
    } up_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        write;
        logic [2:0]  prot;
    } dn_t;

    up_t uq[$];
    dn_t dq[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  n_tevt = 0;
    int  cfg_wait = 0;
    logic [31:0] cfg_rdata = '0;
    logic        cfg_slverr = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream slave: inserts cfg_wait wait cycles, then returns cfg_rdata/cfg_slverr.
    initial begin
        int wcnt;
        wcnt = 0;
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (m_psel && m_penable) begin
                if (wcnt == cfg_wait) begin
                    m_pready = 1'b1; m_prdata = cfg_rdata; m_pslverr = cfg_slverr;
                end else begin
                    m_pready = 1'b0; m_prdata = 32'hBAD0_BAD0; m_pslverr = 1'b1;
                    wcnt++;
                end
            end else begin
                m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0; wcnt = 0;
            end
        end
    end

    // Downstream request monitor: one setup cycle, then the captured request at access entry.
    initial begin
        bit in_acc;
        int n_setup;
        dn_t e;
        in_acc = 0; n_setup = 0;
        forever begin
            @(negedge clk);
            if (m_psel && !m_penable) n_setup++;
            if (m_psel && m_penable && !in_acc) begin
                in_acc = 1;
                chk("dn_setup_cycles", n_setup, 1);
                n_setup = 0;
                if (dq.size() == 0) begin
                    chk("dn_unexpected_access", m_psel, 0);
                end else begin
                    e = dq.pop_front();
                    chk("dn_paddr", m_paddr, e.addr);
                    chk("dn_pwdata", m_pwdata, e.wdata);
                    chk("dn_pstrb", m_pstrb, e.strb);
                    chk("dn_pwrite", m_pwrite, e.write);
                    chk("dn_pprot", m_pprot, e.prot);
                end
            end
            if (!m_psel) in_acc = 0;
        end
    end

    // Upstream response monitor.
    initial begin
        up_t e;
        forever begin
            @(negedge clk);
            if (tevt) n_tevt++;
            if (s_pready) begin
                if (uq.size() == 0) begin
                    chk("up_unexpected_pready", s_pready, 0);
                end else begin
                    e = uq.pop_front();
                    chk("up_prdata", s_prdata, e.rdata);
                    chk("up_pslverr", s_pslverr, e.slverr);
                    chk("up_timeout_evt", tevt, e.tevt);
                    chk("up_latency", cyc, e.cyc);
                end
            end else begin
                chk("up_idle_prdata", s_prdata, 0);
                chk("up_idle_pslverr", s_pslverr, 0);
            end
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int wt,
                        input logic [31:0] rdata, input logic slverr, input logic tmo);
        int n;
        cfg_wait   = tmo ? 1000 : wt;
        cfg_rdata  = rdata;
        cfg_slverr = slverr;
        uq.push_back('{rdata: (tmo || wr) ? 32'h0 : rdata, slverr: tmo | slverr,
                       tevt: tmo, cyc: cyc + 3 + (tmo ? G_TMO : wt)});
        dq.push_back('{addr: addr, wdata: wdata, strb: wr ? strb : 4'h0, write: wr, prot: prot});
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr;
        s_paddr = addr; s_pwdata = wdata; s_pstrb = strb; s_pprot = prot;
        @(posedge clk); #1;
        s_penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_pready && n < 100);
        if (n >= 100) chk("xfer_wait_bound", s_pready, 1);
        @(posedge clk); #1;
        s_psel = 1'b0; s_penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_psel = 0; s_penable = 0; s_pwrite = 0; s_pprot = 0;
        s_paddr = 0; s_pwdata = 0; s_pstrb = 0;
        #2 rst = 1'b0;
        idle(3);
        chk("rst_m_psel", m_psel, 0);
        chk("rst_m_penable", m_penable, 0);
        chk("rst_m_paddr", m_paddr, 0);
        chk("rst_s_pready", s_pready, 0);
        chk("rst_s_prdata", s_prdata, 0);
        chk("rst_timeout_evt", tevt, 0);
        rst = 1'b1;
        idle(2);

        // Write, zero wait; downstream read data must not leak upstream.
        xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'h5555_AAAA, 1'b0, 1'b0);
        idle(2);
        // Read with strobes set, three waits.
        xfer(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b001, 3, 32'h1234_5678, 1'b0, 1'b0);
        idle(1);
        // Downstream error on a write.
        xfer(1'b1, 32'h0000_0030, 32'h0F0F_0F0F, 4'h3, 3'b000, 1, 32'h0, 1'b1, 1'b0);
        idle(1);
        // Back-to-back write then read.
        xfer(1'b1, 32'h0000_0040, 32'hA5A5_0F0F, 4'h5, 3'b100, 0, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b011, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
        // Ready on exactly the limit cycle completes normally.
        xfer(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b000, G_TMO, 32'h0BAD_CAFE, 1'b0, 1'b0);
`ifdef APB_BRIDGE_TIMEOUT_EN
        xfer(1'b0, 32'h0000_0080, 32'h0, 4'hF, 3'b000, 0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        xfer(1'b1, 32'h0000_0084, 32'h1111_2222, 4'hF, 3'b000, 1, 32'h0, 1'b0, 1'b0);
`else
        xfer(1'b0, 32'h0000_0080, 32'h0, 4'hF, 3'b000, 10, 32'h7777_8888, 1'b0, 1'b0);
`endif
        idle(2);

        // Upstream drops psel mid-transfer: downstream completes, no upstream response.
        cfg_wait = 2; cfg_rdata = 32'h9999_0000; cfg_slverr = 1'b0;
        dq.push_back('{addr: 32'h60, wdata: 32'h0, strb: 4'h0, write: 1'b0, prot: 3'b000});
        s_psel = 1; s_penable = 0; s_pwrite = 0; s_paddr = 32'h60; s_pstrb = 4'hF; s_pprot = 0;
        idle(1);
        s_penable = 1;
        idle(1);
        s_psel = 0; s_penable = 0;
        idle(8);
        chk("viol_m_psel_idle", m_psel, 0);
        xfer(1'b1, 32'h0000_0064, 32'h3333_4444, 4'hC, 3'b000, 0, 32'h0, 1'b0, 1'b0);
        idle(1);

        // Reset in ACCESS: downstream request drops at once, nothing issued afterwards.
        cfg_wait = 50; cfg_rdata = 32'h0; cfg_slverr = 1'b0;
        dq.push_back('{addr: 32'h70, wdata: 32'hAAAA_5555, strb: 4'hF, write: 1'b1, prot: 3'b000});
        s_psel = 1; s_penable = 0; s_pwrite = 1; s_paddr = 32'h70; s_pwdata = 32'hAAAA_5555;
        s_pstrb = 4'hF; s_pprot = 0;
        idle(1);
        s_penable = 1;
        idle(2);
        chk("pre_rst_m_penable", m_penable, 1);
        rst = 1'b0;
        #1;
        chk("rst_async_m_psel", m_psel, 0);
        chk("rst_async_m_penable", m_penable, 0);
        s_psel = 0; s_penable = 0;
        idle(2);
        rst = 1'b1;
        idle(6);
        xfer(1'b0, 32'h0000_0074, 32'h0, 4'h0, 3'b000, 1, 32'h5A5A_A5A5, 1'b0, 1'b0);
        idle(3);

        chk("end_up_queue_empty", uq.size(), 0);
        chk("end_dn_queue_empty", dq.size(), 0);
        chk("timeout_evt_pulses", n_tevt, C_EXP_TEVT);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
